// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with oversampled bit timing.
// The line passes through a 2-flop synchronizer. A free-running divider
// produces sample ticks and is re-aligned on each start edge. Every frame
// ends in exactly one pulse: rx_ready_o for a good stop bit, or
// frame_error_o for a bad one.
module uart_receiver #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_ready_o,
   output logic       frame_error_o
);

   localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } state_e;

   state_e              state_q, state_d;
   logic                rx_meta_q, rx_sync_q;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          rx_data_q, rx_data_d;
   logic                rx_ready_q, rx_ready_d;
   logic                frame_error_q, frame_error_d;
   logic                tick;

   assign tick          = (div_cnt_q == DIV_LAST);
   assign rx_data_o     = rx_data_q;
   assign rx_ready_o    = rx_ready_q;
   assign frame_error_o = frame_error_q;

   // Two-flop synchronizer. Both flops reset to the idle-high level so a
   // reset can never look like a start edge.
   // NOTE: sequential state uses non-blocking (<=). With blocking (=),
   // rx_sync_q would pick up rx_i in the same cycle and the second stage
   // would vanish.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
      end
   end

   // State, counters, shift register and output registers.
   // NOTE: every flop here is reset, including the shift register. This
   // keeps the outputs and the partial byte at a known zero after a reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         div_cnt_q     <= '0;
         tick_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_ready_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_ready_q    <= rx_ready_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Next-state and datapath: the start edge re-aligns the divider, and
   // the line is sampled at mid-bit on ticks.
   // NOTE: every signal gets a default first. Then a branch that does not
   // assign a signal simply holds it, and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
      tick_cnt_d    = tick_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_ready_d    = 1'b0;
      frame_error_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) begin
               state_d    = ST_START;
               div_cnt_d  = '0;
               tick_cnt_d = '0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (tick_cnt_q == HALF_LAST) begin
                  // Mid start bit: a high line here was only a glitch.
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_sync_q, shift_q[7:1]};
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_STOP;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  tick_cnt_d = '0;
                  if (rx_sync_q) begin
                     rx_data_d  = shift_q;
                     rx_ready_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     frame_error_d = 1'b1;
                     state_d       = ST_WAIT_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         ST_WAIT_IDLE: begin
            // Ignore a break or a stuck-low line until it returns high.
            if (rx_sync_q) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames, with a queue-based scoreboard checked by
// a separate monitor. The bit period is 160 cycles (DIV = 10, x16).
module tb_uart_receiver;

   localparam int BIT = 160;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_error;

   int         n_checks;
   int         n_errors;
   int         cyc;
   int         ready_cnt;
   int         ferr_cnt;
   int         pulse_cyc;
   int         start_cyc;
   int         stable_viol;
   logic [7:0] last_data;
   logic [7:0] exp_q[$];

   uart_receiver #(
      .CLK_FREQ_HZ (1_600_000),
      .BAUD_RATE   (10_000),
      .OVERSAMPLE  (16)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rx_i          (rx),
      .rx_data_o     (rx_data),
      .rx_ready_o    (rx_ready),
      .frame_error_o (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: pop the scoreboard on each rx_ready pulse, count the pulses
   // and track the stability of rx_data.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_data = 8'h00;
      end else begin
         if (rx_ready || frame_error)
            check("no_overlap", {31'd0, rx_ready & frame_error}, 32'd0);
         if (frame_error)
            ferr_cnt++;
         if (rx_ready) begin
            ready_cnt++;
            pulse_cyc = cyc;
            last_data = rx_data;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_ready: got 0x%0h, expected no pulse", rx_data);
            end else begin
               check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end else if (rx_data !== last_data) begin
            stable_viol++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame LSB-first. A good frame pushes its byte.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      if (stop)
         exp_q.push_back(b);
      rx        = 1'b0;
      start_cyc = cyc;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(BIT);
      end
      rx = stop;
      idle(BIT);
   endtask

   initial begin
      logic [7:0] b2b [6];
      b2b = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      n_checks = 0; n_errors = 0; cyc = 0;
      ready_cnt = 0; ferr_cnt = 0; pulse_cyc = 0; stable_viol = 0;
      rx = 1'b1;
      rst_n = 1'b0;
      idle(5);
      check("reset_data", {24'd0, rx_data}, 32'h0);
      check("reset_ready", {31'd0, rx_ready}, 32'd0);
      check("reset_ferr", {31'd0, frame_error}, 32'd0);
      rst_n = 1'b1;
      idle(20);

      // Single frame; the pulse is due 9.5 bit periods plus synchronizer delay later.
      send_frame(8'hA5, 1'b1);
      check("a5_pulse_count", ready_cnt, 32'd1);
      check("a5_latency_ok", {31'd0, (pulse_cyc - start_cyc >= 1510) && (pulse_cyc - start_cyc <= 1532)}, 32'd1);
      idle(BIT);

      // Back-to-back frames with no idle bits between them.
      foreach (b2b[i]) send_frame(b2b[i], 1'b1);
      idle(BIT);
      check("b2b_pulse_count", ready_cnt, 32'd7);

      // 3-cycle glitch: no output, then a normal frame.
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(2 * BIT);
      check("glitch_no_ready", ready_cnt, 32'd7);
      check("glitch_no_ferr", ferr_cnt, 32'd0);
      send_frame(8'h5A, 1'b1);
      idle(BIT);

      // Bad stop bit followed by a 2-bit break, then recovery.
      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      idle(2 * BIT);
      check("break_ferr_count", ferr_cnt, 32'd1);
      check("break_data_held", {24'd0, rx_data}, 32'h5A);
      rx = 1'b1;
      idle(BIT);
      check("break_no_ready", ready_cnt, 32'd8);
      send_frame(8'h7E, 1'b1);
      idle(BIT);

      // Reset during data bit 4 of 0xFF aborts the frame.
      rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         idle(BIT);
      end
      idle(40);
      rst_n = 1'b0;
      idle(3);
      check("midrst_data", {24'd0, rx_data}, 32'h0);
      check("midrst_ready", {31'd0, rx_ready}, 32'd0);
      check("midrst_ferr", {31'd0, frame_error}, 32'd0);
      idle(20);
      rst_n = 1'b1;
      idle(BIT - 63 + 3 * BIT + BIT + BIT);
      check("midrst_no_pulse", ready_cnt, 32'd9);
      send_frame(8'h81, 1'b1);

      // Drain the scoreboard within a bounded time.
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) idle(1);
      check("sb_empty", exp_q.size(), 32'd0);
      check("ready_total", ready_cnt, 32'd10);
      check("ferr_total", ferr_cnt, 32'd1);
      check("final_data", {24'd0, rx_data}, 32'h81);
      check("data_stable", stable_viol, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 SHALL have port clk_i, input, 1 bit: the single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data_o, output, 8 bits: last correctly framed byte.
REQ-008 SHALL have port rx_ready_o, output, 1 bit: one-cycle pulse, rx_data_o holds a new byte; feeds the loader's rx_ready_i.
REQ-009 SHALL have port frame_error_o, output, 1 bit: one-cycle pulse on invalid stop bit.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-011 SHALL generate a sample tick every DIV = floor(CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE)) cycles, min 1; default DIV = 54.
REQ-012 SHALL clear the tick divider and the sample counter on start-edge detection, aligning ticks to the frame.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: synchronized line = 0 -> START.
REQ-015 START: at tick OVERSAMPLE/2 (mid start bit), line = 0 -> DATA with sample counter cleared; line = 1 -> IDLE (glitch, no output).
REQ-016 DATA: every OVERSAMPLE ticks, sample the line, shift into bit [7] of an 8-bit shift register (right shift, LSB-first); after 8 samples -> STOP.
REQ-017 STOP: after OVERSAMPLE ticks, sample the line; 1 -> load rx_data_o from shift register, pulse rx_ready_o, go IDLE; 0 -> pulse frame_error_o, leave rx_data_o unchanged, go WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until the synchronized line = 1, then IDLE; no start detection while in it (break/stuck-low safe).
REQ-019 rx_ready_o and frame_error_o SHALL each be high for exactly one cycle per frame and never simultaneously.
REQ-020 rx_data_o SHALL be stable from the rx_ready_o pulse until the next rx_ready_o pulse.
REQ-021 Latency: the rx_ready_o pulse SHALL occur 9.5 bit periods ±1 tick after the line's falling start edge, plus 2 cycles of synchronizer delay.
REQ-022 No backpressure or buffering: a consumer that misses the pulse loses the byte; the next start bit is accepted immediately in IDLE, giving back-to-back frames with zero idle bits.

Reset
REQ-023 On rst_ni = 0, the block SHALL immediately force state IDLE, rx_data_o = 0x00, rx_ready_o = 0, frame_error_o = 0, shift register = 0, counters = 0, and synchronizer = 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes only at the next falling edge seen in IDLE.

Verification (bench parameters: CLK_FREQ_HZ = 1_600_000, BAUD_RATE = 10_000 -> DIV = 10, 160 cycles per bit)
REQ-025 Single frame 0xA5 -> exactly one rx_ready_o pulse, rx_data_o = 0xA5, frame_error_o never high, pulse at cycle 1520 ±10 (+2) after the start edge.
REQ-026 Back-to-back frames 0x00, 0x02, 0xAA, 0xBB, 0xCC, 0xDD, no idle gap (loader header and first word) -> six pulses, bytes in order, no byte lost.
REQ-027 Line low for 3 cycles, then high -> no rx_ready_o and no frame_error_o; state back in IDLE; a following frame 0x5A is received correctly.
REQ-028 Frame 0x3C with stop bit = 0, line held low for 2 more bit periods, then high, then frame 0x7E -> one frame_error_o pulse, no rx_ready_o, rx_data_o stays at its prior value through the break, then one pulse with rx_data_o = 0x7E.
REQ-029 rst_ni low during data bit 4 of 0xFF, released, then frame 0x81 -> all outputs 0 during reset, no pulse for the aborted frame, exactly one pulse with rx_data_o = 0x81.
